// File: rtl/shift_sub_divider_8_bits.sv
// Sequential restoring (shift-subtract) unsigned divider, one quotient bit per clock.
// Subtraction is performed as R + ~D + 1; the carry-out doubles as the "no borrow" flag.
module shift_sub_divider_8_bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: a request is taken when start is high on a rising edge in IDLE;
  // operands are captured on that edge only. Results are valid while done is
  // high and stay held until the following request is completed.

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   t;
  logic             no_borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // One iteration: shift the next dividend bit into R, then try R - D.
  always_comb begin
    s                = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    {no_borrow, t}   = {1'b0, s} + {1'b0, ~{1'b0, d_q}} + (WIDTH + 2)'(1);
    r_next           = no_borrow ? t : s;
    q_next           = {q_q[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              // Divide by zero skips iterations entirely.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              r_q         <= '0;
              q_q         <= dividend;
              d_q         <= divisor;
              count       <= '0;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              state       <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_q   <= r_next;
          q_q   <= q_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
            busy      <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

  // The partial remainder is always below D, so its extra top bit stays clear
  // between iterations; it only carries meaning inside the trial subtraction.
  a_r_top_clear: assert property (@(posedge clk) disable iff (!rst_n)
    (state != S_CALC) || !r_q[WIDTH]);

  a_busy_calc: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state == S_CALC));

endmodule

// File: tb/tb_shift_sub_divider_8_bits.sv
// Directed and swept checks of the shift-subtract divider: latency, pulse width,
// boundary operands, divide-by-zero, ignored starts and mid-operation reset.
module tb_shift_sub_divider_8_bits;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic [1:0] state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  shift_sub_divider_8_bits #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one division and follow it to its done pulse. All sampling is on
  // the falling edge. With inject set, 50/3 is pulsed once during CALC and
  // once while the FSM sits in DONE; both must be ignored.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input bit inject, input string tag);
    int cyc;
    int busy_cnt;
    logic [7:0] pq;
    logic [7:0] pr;
    pq = quotient;
    pr = remainder;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom); divisor = 8'($urandom);
    cyc = 1;
    busy_cnt = int'(busy);
    while (!done && cyc < 30) begin
      if (busy) begin
        check({tag, "_q_held"}, quotient, pq);
        check({tag, "_r_held"}, remainder, pr);
      end
      start = 1'b0;
      if (inject && (cyc == 3 || state_dbg == S_DONE)) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd3;
      end
      @(negedge clk);
      cyc++;
      busy_cnt += int'(busy);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_latency"}, cyc, (b == 8'd0) ? 2 : 10);
    check({tag, "_busy_cycles"}, busy_cnt, (b == 8'd0) ? 0 : 8);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_div_by_zero"}, div_by_zero, edz);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_q_after"}, quotient, eq);
  endtask

  initial begin
    bit saw_done;
    logic [7:0] a;
    logic [7:0] b;
    rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 8'd0);
    check("rst_remainder", remainder, 8'd0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_state", state_dbg, S_IDLE);
    rst_n = 1'b1;

    run_div(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0, "d100_7");
    run_div(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0, "d255_1");
    run_div(8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 1'b0, "d200_200");
    run_div(8'd5,   8'd10,  8'd0,   8'd5,   1'b0, 1'b0, "d5_10");
    run_div(8'd255, 8'd129, 8'd1,   8'd126, 1'b0, 1'b0, "d255_129");
    run_div(8'd0,   8'd9,   8'd0,   8'd0,   1'b0, 1'b0, "d0_9");
    run_div(8'd37,  8'd0,   8'd255, 8'd37,  1'b1, 1'b0, "d37_0");
    run_div(8'd37,  8'd5,   8'd7,   8'd2,   1'b0, 1'b0, "d37_5");
    run_div(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b1, "ignore_start");
    run_div(8'd50,  8'd3,   8'd16,  8'd2,   1'b0, 1'b0, "d50_3");

    // Reset at the 4th CALC edge of 255/3.
    @(negedge clk);
    start = 1'b1; dividend = 8'd255; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_quotient", quotient, 8'd0);
    check("midrst_remainder", remainder, 8'd0);
    check("midrst_dbz", div_by_zero, 1'b0);
    check("midrst_state", state_dbg, S_IDLE);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 1'b0);
    run_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 1'b0, "d9_2");

    // Sweep against the language's own / and %.
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = (i % 50 == 0) ? 8'd0 : 8'($urandom);
      if (b == 8'd0)
        run_div(a, b, 8'd255, a, 1'b1, 1'b0, "sweep");
      else
        run_div(a, b, a / b, a % b, 1'b0, 1'b0, "sweep");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
